ps2_frame_rx: RTL and testbench

Front-end receiver for the PS/2 keyboard path. It sits directly upstream of the scancode decoder and 7-segment logic.
- Synchronizes and de-glitches the raw PS2Clk/datai pins.
- Deserializes the 11-bit device-to-host frame (start, 8 data LSB-first, odd parity, stop).
- Presents each good byte as code plus a one-cycle code_valid strobe.
- Reports malformed or stalled frames on frame_err/err_code.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_sync_filter.sv | 43 ++++
 rtl/ps2_frame_rx.sv | 147 ++++++++++++++
 tb/tb_ps2_frame_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_PARITY  = 2'b01,
        ERR_STOP    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_t;

    // start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS = 11;

    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned timeout_us);
        return (clk_hz / 32'd1_000_000) * timeout_us;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// PS2Clk synchronizer, glitch filter and registered falling-edge detector.
module ps2_sync_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    output logic filt,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
            filt <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ps2_clk};
            fall <= 1'b0;
            if (synced == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                // FILTER_LEN-th consecutive differing sample: commit the change
                filt <= synced;
                cnt  <= '0;
                fall <= ~synced;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: deserializes start/8 data/odd parity/stop
// frames and reports good bytes, parity/stop faults and mid-frame stalls.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_US  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2Clk,
    input  logic       datai,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int unsigned TIMEOUT_CYC = timeout_cycles(CLK_HZ, TIMEOUT_US);
    localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned DATA_BITS   = FRAME_BITS - 3;
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

    logic                   clk_filt;
    logic                   fall;
    logic                   edge_ev;
    logic [SYNC_STAGES-1:0] dsync;
    logic                   data;

    rx_state_t  state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic       par, par_n;
    logic [7:0] code_n;
    logic       code_valid_n, frame_err_n;
    err_t       err_q, err_n;
    logic [TW-1:0] tcnt, tcnt_n;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (PS2Clk),
        .filt    (clk_filt),
        .fall    (fall)
    );

    // fall is only ever raised together with the filtered clock going low
    assign edge_ev = fall & ~clk_filt;
    assign data    = dsync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            dsync <= '1;
        end else begin
            dsync <= {dsync[SYNC_STAGES-2:0], datai};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_q      <= ERR_NONE;
            tcnt       <= '0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par        <= par_n;
            code       <= code_n;
            code_valid <= code_valid_n;
            frame_err  <= frame_err_n;
            err_q      <= err_n;
            tcnt       <= tcnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        par_n        = par;
        code_n       = code;
        code_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        err_n        = err_q;
        tcnt_n       = (state == IDLE || edge_ev) ? '0 : tcnt + 1'b1;

        // an edge in the terminal-count cycle wins over the timeout
        if (state != IDLE && !edge_ev && tcnt == TW'(TIMEOUT_CYC)) begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
            err_n       = ERR_TIMEOUT;
            tcnt_n      = '0;
        end else if (edge_ev) begin
            case (state)
                IDLE: begin
                    if (!data) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n[bit_cnt] = data;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    par_n   = data;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!data) begin
                        frame_err_n = 1'b1;
                        err_n       = ERR_STOP;
                    end else if (^{shreg, par} != 1'b1) begin
                        frame_err_n = 1'b1;
                        err_n       = ERR_PARITY;
                    end else begin
                        code_n       = shreg;
                        code_valid_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign err_code = err_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx with a scaled clock so timeouts stay short.
module tb_ps2_frame_rx;

    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILTER_LEN  = 8;
    localparam int unsigned TIMEOUT_US  = 200;
    localparam int unsigned T_CYC       = 200;
    localparam int unsigned HALF        = 40;
    localparam int unsigned LAT         = SYNC_STAGES + FILTER_LEN + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PS2Clk = 1'b1;
    logic       datai = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned fall_cyc = 0;
    int unsigned valid_cyc = 0;
    int unsigned err_cyc  = 0;
    int unsigned n_valid  = 0;
    int unsigned n_err    = 0;
    int unsigned n_both   = 0;
    int unsigned n_fall   = 0;
    int unsigned n_busy   = 0;
    logic [7:0] last_code = 8'h00;
    logic [7:0] prev_code = 8'h00;

    ps2_frame_rx #(
        .CLK_HZ      (CLK_HZ),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_US  (TIMEOUT_US)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PS2Clk     (PS2Clk),
        .datai      (datai),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (code_valid) begin
                n_valid++;
                prev_code = last_code;
                last_code = code;
                valid_cyc = cyc;
            end
            if (frame_err) begin
                n_err++;
                err_cyc = cyc;
            end
            if (code_valid && frame_err) n_both++;
            if (dut.u_filt.fall) n_fall++;
            if (busy) n_busy++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        datai = v;
        wait_cyc(HALF);
        PS2Clk   = 1'b0;
        fall_cyc = cyc;
        wait_cyc(HALF);
        PS2Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic glitch(input int unsigned n);
        PS2Clk = 1'b0;
        wait_cyc(n);
        PS2Clk = 1'b1;
        wait_cyc(30);
    endtask

    int unsigned v0, e0, f0, b0;

    initial begin
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        check_eq("rst_code", 32'(code), 32'h00);
        check_eq("rst_valid", 32'(code_valid), 0);
        check_eq("rst_err", 32'(frame_err), 0);
        check_eq("rst_errcode", 32'(err_code), 0);
        check_eq("rst_busy", 32'(busy), 0);

        // good frame 0x1C and stop-edge to strobe latency
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_cyc(10);
        check_eq("f1c_count", n_valid - v0, 1);
        check_eq("f1c_code", 32'(last_code), 32'h1C);
        check_eq("f1c_latency", valid_cyc - fall_cyc, LAT);
        check_eq("f1c_noerr", n_err - e0, 0);
        check_eq("f1c_busy", 32'(busy), 0);

        // back-to-back 0xF0, 0x1C
        v0 = n_valid;
        send_frame(8'hF0, 1'b1, 1'b1);
        check_eq("b2b_busy_gap", 32'(busy), 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_cyc(10);
        check_eq("b2b_count", n_valid - v0, 2);
        check_eq("b2b_first", 32'(prev_code), 32'hF0);
        check_eq("b2b_second", 32'(last_code), 32'h1C);

        // parity error, then stop error (also bad parity: stop takes priority)
        v0 = n_valid; e0 = n_err;
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_cyc(10);
        check_eq("par_err", n_err - e0, 1);
        check_eq("par_code", 32'(err_code), 32'h1);
        check_eq("par_novalid", n_valid - v0, 0);
        check_eq("par_keep", 32'(code), 32'h1C);
        send_frame(8'h5A, 1'b0, 1'b0);
        wait_cyc(10);
        check_eq("stop_err", n_err - e0, 2);
        check_eq("stop_code", 32'(err_code), 32'h2);
        check_eq("stop_keep", 32'(code), 32'h1C);

        // stall after start + 5 data bits
        e0 = n_err; v0 = n_valid;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        wait_cyc(250);
        check_eq("to_err", n_err - e0, 1);
        check_eq("to_code", 32'(err_code), 32'h3);
        check_eq("to_latency", err_cyc - fall_cyc, LAT + T_CYC + 1);
        check_eq("to_busy", 32'(busy), 0);
        check_eq("to_novalid", n_valid - v0, 0);
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_cyc(10);
        check_eq("to_recover", 32'(code), 32'h5A);
        check_eq("to_errhold", 32'(err_code), 32'h3);

        // glitches while idle
        datai = 1'b1;
        wait_cyc(10);
        f0 = n_fall; b0 = n_busy; v0 = n_valid; e0 = n_err;
        glitch(3);
        glitch(7);
        check_eq("gl_short_fall", n_fall - f0, 0);
        glitch(8);
        check_eq("gl_8_fall", n_fall - f0, 1);
        check_eq("gl_busy", n_busy - b0, 0);
        check_eq("gl_pulses", (n_valid - v0) + (n_err - e0), 0);

        // reset mid-frame after 4 data bits of 0x1C
        v0 = n_valid; e0 = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i < 2 ? 1'b0 : 1'b1);
        check_eq("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        datai = 1'b1;
        wait_cyc(30);
        check_eq("mr_code", 32'(code), 32'h00);
        check_eq("mr_errcode", 32'(err_code), 0);
        check_eq("mr_busy", 32'(busy), 0);
        check_eq("mr_pulses", (n_valid - v0) + (n_err - e0), 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_cyc(10);
        check_eq("mr_frame", 32'(code), 32'h1C);
        check_eq("mr_count", n_valid - v0, 1);

        check_eq("never_both", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
